// File: rtl/ext_pkg.sv
// Shared definitions for the immediate-extension pipeline: mode encodings and counter width.
package ext_pkg;

    localparam logic [2:0] EXT_SIGN    = 3'd0;
    localparam logic [2:0] EXT_ZERO    = 3'd1;
    localparam logic [2:0] EXT_UPPER   = 3'd2;
    localparam logic [2:0] EXT_SIGN_SH = 3'd3;
    localparam logic [2:0] EXT_ZERO_SH = 3'd4;
    localparam logic [2:0] EXT_LINK    = 3'd5;

    localparam int unsigned ERR_CNT_W = 8;

endpackage

// File: rtl/ext_fifo2.sv
// Two-entry FIFO; entry 0 is always the head so the output is a plain register.
module ext_fifo2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem0_q, mem0_d;
    logic [WIDTH-1:0] mem1_q, mem1_d;
    logic [1:0]       count_q, count_d;
    logic             push_ok, pop_ok;

    always_comb begin
        push_ok = push_i && (count_q != 2'd2);
        pop_ok  = pop_i && (count_q != 2'd0);
        mem0_d  = mem0_q;
        mem1_d  = mem1_q;
        count_d = count_q;
        if (pop_ok) begin
            mem0_d = mem1_q;
        end
        // New data lands in the head slot whenever the head is (or is becoming) free.
        if (push_ok) begin
            if ((count_q == 2'd0) || pop_ok) begin
                mem0_d = push_data_i;
            end else begin
                mem1_d = push_data_i;
            end
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem0_q  <= '0;
            mem1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            mem0_q  <= mem0_d;
            mem1_q  <= mem1_d;
            count_q <= count_d;
        end
    end

    assign head_o  = mem0_q;
    assign count_o = count_q;

endmodule

// File: rtl/ext_pipe.sv
// Immediate-extension stage with valid/ready handshake, 2-deep result buffer and
// saturating illegal-mode counter.
module ext_pipe
    import ext_pkg::*;
#(
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SHAMT  = 2,
    parameter int unsigned TAG_W  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IMM_W-1:0]     in_imm,
    input  logic [2:0]           in_mode,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int unsigned PAY_W = DATA_W + TAG_W + 1;

    logic [DATA_W-1:0]    sext, zext, res_data;
    logic                 res_err;
    logic                 accept, pop;
    logic [1:0]           count;
    logic [PAY_W-1:0]     head;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        sext              = {DATA_W{in_imm[IMM_W-1]}};
        sext[IMM_W-1:0]   = in_imm;
        zext              = '0;
        zext[IMM_W-1:0]   = in_imm;
        res_data          = '0;
        res_err           = 1'b0;
        case (in_mode)
            EXT_SIGN:    res_data = sext;
            EXT_ZERO:    res_data = zext;
            EXT_UPPER:   res_data = zext << (DATA_W - IMM_W);
            EXT_SIGN_SH: res_data = sext << SHAMT;
            EXT_ZERO_SH: res_data = zext << SHAMT;
            EXT_LINK: begin
                res_data    = sext << SHAMT;
                res_data[0] = 1'b1;
            end
            default:     res_err  = 1'b1;
        endcase
    end

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    ext_fifo2 #(
        .WIDTH(PAY_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (accept),
        .push_data_i({res_data, in_tag, res_err}),
        .pop_i      (pop),
        .head_o     (head),
        .count_o    (count)
    );

    assign {out_data, out_tag, out_err} = head;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && res_err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_ext_pipe.sv
// Directed self-checking bench for ext_pipe (default parameters plus a narrow instance).
module tb_ext_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, out_err;
    logic [15:0] in_imm;
    logic [2:0]  in_mode;
    logic [4:0]  in_tag, out_tag;
    logic [31:0] out_data;
    logic [7:0]  err_cnt;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_err;
    logic [7:0]  s_in_imm;
    logic [2:0]  s_in_mode;
    logic [4:0]  s_in_tag, s_out_tag;
    logic [15:0] s_out_data;
    logic [7:0]  s_err_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ext_pipe u_dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_imm   (in_imm),
        .in_mode  (in_mode),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_tag  (out_tag),
        .out_err  (out_err),
        .err_cnt  (err_cnt)
    );

    ext_pipe #(
        .IMM_W (8),
        .DATA_W(16),
        .SHAMT (1),
        .TAG_W (5)
    ) u_dut_small (
        .clk      (clk),
        .reset    (reset),
        .in_valid (s_in_valid),
        .in_ready (s_in_ready),
        .in_imm   (s_in_imm),
        .in_mode  (s_in_mode),
        .in_tag   (s_in_tag),
        .out_valid(s_out_valid),
        .out_ready(s_out_ready),
        .out_data (s_out_data),
        .out_tag  (s_out_tag),
        .out_err  (s_out_err),
        .err_cnt  (s_err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request for exactly one rising edge, then step 1 time unit past it.
    task automatic beat(input logic [15:0] imm, input logic [2:0] mode, input logic [4:0] tag);
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = mode;
        in_tag   = tag;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic s_beat(input logic [7:0] imm, input logic [2:0] mode);
        s_in_valid = 1'b1;
        s_in_imm   = imm;
        s_in_mode  = mode;
        s_in_tag   = 5'd9;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_mode [6];

    initial begin
        exp_mode[0] = 32'hFFFF_8004;
        exp_mode[1] = 32'h0000_8004;
        exp_mode[2] = 32'h8004_0000;
        exp_mode[3] = 32'hFFFE_0010;
        exp_mode[4] = 32'h0002_0010;
        exp_mode[5] = 32'hFFFE_0011;

        reset = 1'b1;
        in_valid = 1'b0; in_imm = '0; in_mode = '0; in_tag = '0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_imm = '0; s_in_mode = '0; s_in_tag = '0; s_out_ready = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", out_data, 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        #12;
        reset = 1'b0;

        for (int m = 0; m < 6; m++) begin
            beat(16'h8004, 3'(m), 5'(m + 10));
            check($sformatf("mode%0d_valid", m), 32'(out_valid), 32'd1);
            check($sformatf("mode%0d_data", m), out_data, exp_mode[m]);
            check($sformatf("mode%0d_tag", m), 32'(out_tag), 32'(m + 10));
            check($sformatf("mode%0d_err", m), 32'(out_err), 32'd0);
        end

        beat(16'h1234, 3'd6, 5'd1);
        check("ill6_data", out_data, 32'd0);
        check("ill6_err", 32'(out_err), 32'd1);
        beat(16'h1234, 3'd7, 5'd2);
        check("ill7_data", out_data, 32'd0);
        check("ill7_err", 32'(out_err), 32'd1);
        check("err_cnt_2", 32'(err_cnt), 32'd2);
        for (int i = 0; i < 300; i++) beat(16'h1234, 3'd6, 5'd0);
        check("err_cnt_sat", 32'(err_cnt), 32'd255);

        // Backpressure: fill, block a third beat, then drain in order.
        step();
        out_ready = 1'b0;
        beat(16'd1, 3'd1, 5'd1);
        beat(16'd2, 3'd1, 5'd2);
        check("bp_full_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1; in_imm = 16'd3; in_mode = 3'd1; in_tag = 5'd3;
        step();
        check("bp_hold_tag", 32'(out_tag), 32'd1);
        check("bp_hold_data", out_data, 32'd1);
        check("bp_hold_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        check("bp_pop1_tag", 32'(out_tag), 32'd2);
        check("bp_pop1_ready", 32'(in_ready), 32'd1);
        step();
        check("bp_pop2_tag", 32'(out_tag), 32'd3);
        check("bp_pop2_data", out_data, 32'd3);
        in_valid = 1'b0;
        step();
        check("bp_empty", 32'(out_valid), 32'd0);

        for (int i = 0; i < 20; i++) begin
            beat(16'(i), 3'd1, 5'(i));
            check($sformatf("bb%0d_tag", i), 32'(out_tag), 32'(i));
            check($sformatf("bb%0d_data", i), out_data, 32'(i));
            check($sformatf("bb%0d_ready", i), 32'(in_ready), 32'd1);
        end
        step();
        check("bb_drained", 32'(out_valid), 32'd0);

        // Asynchronous reset with a full buffer and a non-zero error count.
        reset = 1'b1;
        #2;
        reset = 1'b0;
        check("rst2_err_cnt", 32'(err_cnt), 32'd0);
        for (int i = 0; i < 5; i++) beat(16'h0, 3'd7, 5'd0);
        out_ready = 1'b0;
        beat(16'h00AA, 3'd1, 5'd4);
        beat(16'h00BB, 3'd1, 5'd5);
        check("mid_full", 32'(in_ready), 32'd0);
        check("mid_err_cnt", 32'(err_cnt), 32'd5);
        #2;
        reset = 1'b1;
        #1;
        check("async_valid", 32'(out_valid), 32'd0);
        check("async_ready", 32'(in_ready), 32'd1);
        check("async_data", out_data, 32'd0);
        check("async_tag", 32'(out_tag), 32'd0);
        check("async_err", 32'(out_err), 32'd0);
        check("async_err_cnt", 32'(err_cnt), 32'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        beat(16'h8004, 3'd0, 5'd7);
        check("post_rst_data", out_data, 32'hFFFF_8004);
        check("post_rst_tag", 32'(out_tag), 32'd7);

        s_beat(8'h80, 3'd0);
        check("small_m0", 32'(s_out_data), 32'h0000_FF80);
        s_beat(8'h80, 3'd2);
        check("small_m2", 32'(s_out_data), 32'h0000_8000);
        s_beat(8'h80, 3'd4);
        check("small_m4", 32'(s_out_data), 32'h0000_0100);
        s_beat(8'h80, 3'd5);
        check("small_m5", 32'(s_out_data), 32'h0000_FF01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ext_pipe.md
# ext_pipe

Parametrised, pipelined immediate-extension unit with a valid/ready handshake, sitting between the decode stage and the operand-select mux of the pipelined datapath. Accepts an immediate, a 3-bit mode and a tag, computes the extended operand in one registered stage, and buffers up to two results so backpressure from downstream never drops a beat. Adds zero-shifted and parametrised-shift modes, illegal-mode flagging and a saturating error counter.

## Interface
- IMM_W, 16, immediate width; 1 ≤ IMM_W ≤ DATA_W
- DATA_W, 32, output operand width
- SHAMT, 2, left-shift amount for modes 3/4/5; 0 ≤ SHAMT < DATA_W
- TAG_W, 5, width of sideband tag (e.g. destination register)
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_valid  in  1  request present
- in_ready  out  1  unit can accept a request this cycle
- in_imm  in  IMM_W  raw immediate
- in_mode  in  3  extension mode
- in_tag  in  TAG_W  sideband, passed through unchanged
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result this cycle
- out_data  out  DATA_W  extended operand
- out_tag  out  TAG_W  tag of the result
- out_err  out  1  result came from an illegal mode
- err_cnt  out  8  saturating count of accepted illegal-mode requests

## Operation
- Modes (S = sign-extend imm to DATA_W, Z = zero-extend):
  - 0: S; 1: Z; 2: {imm, (DATA_W−IMM_W) zeros} (upper load; equals imm when DATA_W = IMM_W)
  - 3: S << SHAMT; 4: Z << SHAMT; 5: S << SHAMT, then bit 0 forced 1 (jump-link marker)
  - 6, 7: illegal → data 0, err 1
- Shifts are logical, truncated to DATA_W; no rotation.
- Accept: in_valid && in_ready at a rising edge. Result {data, tag, err} is computed combinationally from inputs and written into a 2-entry FIFO on that edge.
- Emit: out_valid && out_ready at a rising edge pops the head entry.
- in_ready = (count != 2), driven from registered count only; no combinational path from out_ready to in_ready.
- out_valid = (count != 0); out_data/out_tag/out_err show the head entry; results appear in acceptance order.
- err_cnt increments by 1 on each accepted illegal-mode request; saturates at 255; cleared only by reset.

## Timing
- Latency: request accepted at edge N → out_valid high and result on outputs after edge N (visible in cycle N+1) when FIFO was empty.
- Throughput: one result per cycle when out_ready held high.
- count 0, push only → 1; count 1, push+pop → stays 1, new entry becomes head after edge; count 2 → in_ready 0, push impossible; pop only decrements.
- Output must hold stable while out_valid && !out_ready.
- Reset (any time, including mid-stream): count 0, out_valid 0, in_ready 1, out_data 0, out_tag 0, out_err 0, err_cnt 0; buffered entries discarded; first acceptance possible at the first rising edge after reset deasserts.
- in_valid while in_ready 0 has no effect; inputs need not be held (sender's responsibility).

## Structure
- Shared package ext_pkg: mode localparams (EXT_SIGN=0, EXT_ZERO=1, EXT_UPPER=2, EXT_SIGN_SH=3, EXT_ZERO_SH=4, EXT_LINK=5) and ERR_CNT_W = 8.
- One sub-module: ext_fifo2 — 2-entry FIFO, parametrised payload width (DATA_W+TAG_W+1), with count, push, pop, head outputs. Extension logic stays combinational in ext_pipe.

## Test plan
- Defaults, out_ready=1: imm 0x8004 mode 0 → 0xFFFF8004; mode 1 → 0x00008004; mode 2 → 0x80040000; mode 3 → 0xFFFE0010; mode 4 → 0x00020010; mode 5 → 0xFFFE0011; each one cycle after acceptance, tag echoed.
- Illegal: mode 6 then 7, imm 0x1234 → out_data 0, out_err 1 both; err_cnt = 2; 300 illegal beats → err_cnt 255.
- Backpressure: out_ready=0, push three beats → first two accepted, in_ready 0 on third; release out_ready → outputs in order, third accepted after first pop, no loss/duplication.
- Simultaneous push/pop at count 1 over 20 back-to-back beats → count stays 1, one result per cycle, tags sequential 0..19.
- Reset mid-stream with count 2 and err_cnt 5 → all outputs/counters zero immediately (async), in_ready 1; next beat after deassert processed normally.
- Parameter sweep IMM_W=8, DATA_W=16, SHAMT=1: imm 0x80 mode 0 → 0xFF80, mode 2 → 0x8000, mode 4 → 0x0100.
